// File: rtl/peripheral_uart_tx.sv
// UART byte transmitter: start bit, 8 data bits LSB-first, optional even parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit.
module peripheral_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       trans_done
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shreg;
  logic          r_serial;
  logic          r_busy;
  logic          r_done;
  logic          w_serial_next;
  logic          w_busy_next;
  logic          w_done_next;
  logic          w_load;
  logic          w_shift;
  logic          w_bit_end;
  logic          w_stop_last;

  assign w_bit_end   = (r_cnt == CNT_MAX);
  assign w_stop_last = w_bit_end && (r_bit == STOP_LAST);

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_parity <= 1'b0;
    else if (w_load) r_parity <= ^tx_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (tx_valid)  w_state_next = S_START;
      S_START: if (w_bit_end) w_state_next = S_DATA;
      S_DATA: begin
        if (w_bit_end && (r_bit == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_bit_end) w_state_next = S_STOP;
`endif
      S_STOP:  if (w_stop_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; the line changes exactly on bit boundaries.
  always_comb begin
    w_serial_next = r_serial;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_serial_next = 1'b0;
          w_busy_next   = 1'b1;
          w_load        = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_serial_next = r_shreg[0];
          w_shift       = 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift = 1'b1;
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_serial_next = r_parity;
`else
            w_serial_next = 1'b1;
`endif
          end else begin
            w_serial_next = r_shreg[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_bit_end) w_serial_next = 1'b1;
`endif
      S_STOP: begin
        if (w_stop_last) begin
          w_busy_next = 1'b0;
          w_done_next = 1'b1;
        end
      end
      default: begin
        w_serial_next = 1'b1;
        w_busy_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shreg  <= '0;
      r_serial <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_serial <= w_serial_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
      if ((r_state == S_IDLE) || w_bit_end) r_cnt <= '0;
      else                                  r_cnt <= r_cnt + 1'b1;
      // Bit index restarts on every state change, so it serves DATA and STOP alike.
      if (r_state != w_state_next) r_bit <= '0;
      else if (w_bit_end)          r_bit <= r_bit + 1'b1;
      if (w_load)       r_shreg <= tx_data;
      else if (w_shift) r_shreg <= {1'b0, r_shreg[7:1]};
    end
  end

  assign tx_serial  = r_serial;
  assign tx_busy    = r_busy;
  assign trans_done = r_done;

endmodule

// File: tb/tb_peripheral_uart_tx.sv
// Directed bench for peripheral_uart_tx at CLKS_PER_BIT=4; parity build uses STOP_BITS=2.
module tb_peripheral_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int STOP = 2;
  localparam int F    = 10 + STOP;
`else
  localparam int STOP = 1;
  localparam int F    = 9 + STOP;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_serial;
  logic       tx_busy;
  logic       trans_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int done_cnt = 0;

  peripheral_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(STOP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_serial  (tx_serial),
    .tx_busy    (tx_busy),
    .trans_done (trans_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (trans_done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge where trans_done should be high.
  task automatic run_frame(input string tag, input logic [7:0] b, input logic [15:0] exp,
                           input int inj_at, output int acc);
    logic [15:0] obs = '0;
    int unstable = 0;
    int busy_lo  = 0;
    int early    = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    @(posedge clk);
    acc = 0;
    for (int s = 0; s < F * C; s++) begin
      @(negedge clk);
      if (s == 0) begin
        tx_valid = 1'b0;
        acc      = cyc;
      end
      if (s % C == 0) obs[s / C] = tx_serial;
      else if (tx_serial !== obs[s / C]) unstable++;
      if (tx_busy !== 1'b1) busy_lo++;
      if (trans_done !== 1'b0) early++;
      if (s == inj_at) begin
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
      end
      if (s == inj_at + 1) begin
        tx_valid = 1'b0;
        tx_data  = 8'hC3;
      end
    end
    @(negedge clk);
    check({tag, "_frame"}, 32'(obs), 32'(exp));
    check({tag, "_stable"}, unstable, 0);
    check({tag, "_busy"}, busy_lo, 0);
    check({tag, "_early_done"}, early, 0);
    check({tag, "_latency"}, cyc - acc, F * C);
    check({tag, "_done"}, 32'(trans_done), 1);
    check({tag, "_busy_end"}, 32'(tx_busy), 0);
    check({tag, "_line_end"}, 32'(tx_serial), 1);
    $display("tx %s byte=%02h line=%03h", tag, b, obs);
  endtask

  task automatic idle_check(input string tag, input int n, input int done_exp);
    int base = done_cnt;
    int bad  = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || tx_serial !== 1'b1) bad++;
    end
    check({tag, "_idle"}, bad, 0);
    check({tag, "_done_cnt"}, done_cnt - base, done_exp);
  endtask

  initial begin
    int acc;
    int prev;
    int base;
    logic [7:0]  burst_b [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    logic [15:0] burst_f [4] = '{16'h224, 16'h268, 16'h2AC, 16'h2F0};

    rst_n    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_serial", 32'(tx_serial), 1);
      check("rst_busy", 32'(tx_busy), 0);
      check("rst_done", 32'(trans_done), 0);
    end
    rst_n    = 1'b1;
    tx_valid = 1'b0;
    idle_check("rst_release", 20, 0);

`ifdef UART_TX_PARITY_EN
    run_frame("parity07", 8'h07, 16'hE0E, -1, acc);
    idle_check("parity07", 8, 1);
`else
    run_frame("single", 8'hA5, 16'h34A, -1, acc);
    idle_check("single", 8, 1);

    base = done_cnt;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      run_frame($sformatf("burst%0d", i), burst_b[i], burst_f[i], -1, acc);
      if (i > 0) check($sformatf("burst%0d_gap", i), acc - prev, F * C + 1);
      prev = acc;
    end
    idle_check("burst", 8, 1);
    check("burst_total_done", done_cnt - base, 4);

    run_frame("busy_ign", 8'h81, 16'h302, 10, acc);
    idle_check("busy_ign", 3 * F * C, 1);

    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("midrst_bit3", 32'(tx_serial), 0);
    check("midrst_busy_pre", 32'(tx_busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_serial", 32'(tx_serial), 1);
    check("midrst_busy", 32'(tx_busy), 0);
    check("midrst_done", 32'(trans_done), 0);
    rst_n = 1'b1;
    idle_check("midrst", 2 * F * C, 0);
    $display("tx midrst byte=a5 aborted");
    run_frame("post_rst", 8'h5A, 16'h2B4, -1, acc);
    idle_check("post_rst", 8, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
